input_debouncer: RTL

Multi-channel input conditioner that sits directly upstream of the combinational gate blocks such as the two-input AND. It turns raw, asynchronous, bouncing board inputs (switches and push-buttons) into clean, synchronous, debounced levels. Those levels drive the gate inputs, for example `in1`/`in2`. Each channel is synchronised, filtered by a stability counter, and optionally emits single-cycle edge pulses.

---
 rtl/input_debouncer_pkg.sv | 25 ++
 rtl/input_debouncer_channel.sv | 105 ++++++++++
 rtl/input_debouncer.sv | 56 +++++
 3 files changed

// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer_pkg
//  Description : Shared constants and types for the input debouncer.
//                DEBOUNCE_DEFAULT_CYCLES : default stability window
//                                          (4 for simulation; the board build
//                                          overrides it to ~10 ms of clocks).
//                SYNC_STAGES             : synchroniser depth (s1, s2).
//                chan_state_e            : per-channel debounce state.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_debouncer_pkg;

    localparam int DEBOUNCE_DEFAULT_CYCLES = 4;
    localparam int SYNC_STAGES             = 2;

    // STABLE  : synchronised input agrees with the debounced level.
    // PENDING : synchronised input disagrees; the stability counter runs.
    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_e;

endpackage
`default_nettype wire

// File: rtl/input_debouncer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : Single-bit input conditioner: 2-flop synchroniser, stability
//                counter and stable output register, plus optional registered
//                edge pulses when DEBOUNCE_EDGE_EN is defined.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - synchronous active-low reset
//                raw_i   - asynchronous raw pin input
//                sig_o   - debounced level
//                rise_o  - one-cycle pulse on 0->1 of sig_o (DEBOUNCE_EDGE_EN)
//                fall_o  - one-cycle pulse on 1->0 of sig_o (DEBOUNCE_EDGE_EN)
//  Macros      : DEBOUNCE_EDGE_EN - adds rise_o/fall_o and their registers
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic sig_o
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    localparam int                CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   sig_q;
    logic                   sig_d;
    logic                   s2;
    chan_state_e            state;

    always_comb begin
        // Bit 0 is s1 (first flop, may be metastable), the MSB is s2.
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
        s2     = sync_q[SYNC_STAGES-1];
        state  = (s2 == sig_q) ? ST_STABLE : ST_PENDING;
        cnt_d  = '0;
        sig_d  = sig_q;
        unique case (state)
            ST_STABLE: begin
                // Any return to the current level discards a partial count.
                cnt_d = '0;
            end
            ST_PENDING: begin
                if (cnt_q == CNT_LAST) begin
                    sig_d = s2;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            sig_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            sig_q  <= sig_d;
        end
    end

    assign sig_o = sig_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Compare next level against current level so the pulse is registered
    // on the same edge that sig_o takes its new value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= sig_d & ~sig_q;
            fall_q <= ~sig_d & sig_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Multi-channel switch/button conditioner. Each of WIDTH
//                channels is synchronised and debounced independently; the
//                clean levels feed downstream combinational gate inputs.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - synchronous active-low reset
//                raw_in     - [WIDTH] asynchronous raw pin inputs
//                sig_out    - [WIDTH] debounced levels
//                rise_pulse - [WIDTH] 0->1 pulses (DEBOUNCE_EDGE_EN only)
//                fall_pulse - [WIDTH] 1->0 pulses (DEBOUNCE_EDGE_EN only)
//  Parameters  : WIDTH         - channel count
//                STABLE_CYCLES - stability window in clocks, >= 2
//  Macros      : DEBOUNCE_EDGE_EN - enables rise_pulse/fall_pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sig_out
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`endif
);

    if (STABLE_CYCLES < 2) begin : g_bad_cycles
        $error("input_debouncer: STABLE_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw_in[i]),
            .sig_o  (sig_out[i])
`ifdef DEBOUNCE_EDGE_EN
            ,
            .rise_o (rise_pulse[i]),
            .fall_o (fall_pulse[i])
`endif
        );
    end

endmodule
`default_nettype wire
